// File: rtl/gpu_led_pio_pkg.sv
// Shared register map and constants for the GPU LED output PIO.
package gpu_led_pio_pkg;

    localparam logic [2:0] REG_DATA      = 3'd0;
    localparam logic [2:0] REG_SET       = 3'd1;
    localparam logic [2:0] REG_CLR       = 3'd2;
    localparam logic [2:0] REG_BLINK_EN  = 3'd3;
    localparam logic [2:0] REG_BLINK_DIV = 3'd4;
    localparam logic [2:0] REG_DIM       = 3'd5;
    localparam logic [2:0] REG_STATUS    = 3'd6;

    localparam logic [7:0] DIM_FULL = 8'hFF;

endpackage

// File: rtl/gpu_led_blink_timer.sv
// Blink phase generator: phase toggles every div+1 clocks; restart forces count 0, phase 1.
module gpu_led_blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             phase
);

    logic [DIV_W-1:0] blink_cnt;

    // restart has priority so a divider write landing on terminal count wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (restart) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == div) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpu_led_pio.sv
// Avalon-MM output PIO with atomic set/clear, per-channel blink and a global PWM dimmer.
module gpu_led_pio
    import gpu_led_pio_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int DIV_W         = 24,
    parameter int BLINK_DIV_RST = 12_499_999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Bus handshake: no wait states; a write is taken on any edge with
    // chipselect & ~write_n, a read with chipselect & ~read_n returns data
    // on readdata after that edge, and readdata holds between reads.
    logic wr;
    logic rd;
    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] blink_en_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       dim_q;
    logic [7:0]       pwm_cnt;
    logic             phase;
    logic             pwm_on;
    logic             blink_restart;
    logic [31:0]      rd_mux;

    // writedata bits above every register width are intentionally dropped
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    assign blink_restart = wr && (address == REG_BLINK_DIV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_en_q <= '0;
            div_q      <= DIV_W'(BLINK_DIV_RST);
            dim_q      <= DIM_FULL;
        end else if (wr) begin
            case (address)
                REG_DATA:      data_q     <= writedata[WIDTH-1:0];
                REG_SET:       data_q     <= data_q | writedata[WIDTH-1:0];
                REG_CLR:       data_q     <= data_q & ~writedata[WIDTH-1:0];
                REG_BLINK_EN:  blink_en_q <= writedata[WIDTH-1:0];
                REG_BLINK_DIV: div_q      <= writedata[DIV_W-1:0];
                REG_DIM:       dim_q      <= writedata[7:0];
                default:       ;
            endcase
        end
    end

    gpu_led_blink_timer #(
        .DIV_W(DIV_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .div     (div_q),
        .restart (blink_restart),
        .phase   (phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign pwm_on = (dim_q == DIM_FULL) | (pwm_cnt < dim_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= data_q & ~(blink_en_q & {WIDTH{~phase}}) & {WIDTH{pwm_on}};
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_DATA:      rd_mux = 32'(data_q);
            REG_BLINK_EN:  rd_mux = 32'(blink_en_q);
            REG_BLINK_DIV: rd_mux = 32'(div_q);
            REG_DIM:       rd_mux = {24'h0, dim_q};
            REG_STATUS:    rd_mux = {8'h00, 8'(DIV_W), 8'(WIDTH), 7'h00, phase};
            default:       rd_mux = '0;
        endcase
    end

    // Registered read of current state gives the pre-write value on a simultaneous write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpu_led_pio.sv
// Directed self-checking bench for gpu_led_pio with default parameters.
module tb_gpu_led_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int pass_cnt;
    int total_cnt;

    localparam logic [31:0] STATUS_P1 = 32'h0018_0A01;

    gpu_led_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] exp_rd [8];
        logic [31:0] d;
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd12_499_999, 32'hFF, STATUS_P1, 32'h0};
        total_cnt++;
        if (out_port !== 10'h000) $display("FAIL reset_out_port: got %h want %h", out_port, 10'h000);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0);
        else pass_cnt++;
        #13 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i), d);
            total_cnt++;
            if (d !== exp_rd[i]) $display("FAIL reset_read_addr%0d: got %h want %h", i, d, exp_rd[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_port !== 10'h000) $display("FAIL reset_out_after_release: got %h want %h", out_port, 10'h000);
        else pass_cnt++;
    endtask

    task automatic test_set_clr;
        logic [31:0] d;
        do_write(3'd0, 32'h3A5);
        do_write(3'd1, 32'h00F);
        do_write(3'd2, 32'h300);
        tick(1);
        total_cnt++;
        if (out_port !== 10'h0AF) $display("FAIL set_clr_out_port: got %h want %h", out_port, 10'h0AF);
        else pass_cnt++;
        do_read(3'd0, d);
        total_cnt++;
        if (d !== 32'h0AF) $display("FAIL set_clr_data: got %h want %h", d, 32'h0AF);
        else pass_cnt++;
        do_write(3'd1, 32'h0);
        do_write(3'd2, 32'h0);
        do_read(3'd0, d);
        total_cnt++;
        if (d !== 32'h0AF) $display("FAIL set_clr_zero: got %h want %h", d, 32'h0AF);
        else pass_cnt++;
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] d;
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h155;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        total_cnt++;
        if (readdata !== 32'h0AF) $display("FAIL rw_same_old: got %h want %h", readdata, 32'h0AF);
        else pass_cnt++;
        do_read(3'd0, d);
        total_cnt++;
        if (d !== 32'h155) $display("FAIL rw_same_new: got %h want %h", d, 32'h155);
        else pass_cnt++;
        tick(2);
        total_cnt++;
        if (readdata !== 32'h155) $display("FAIL readdata_hold: got %h want %h", readdata, 32'h155);
        else pass_cnt++;
    endtask

    task automatic test_width_reserved;
        logic [31:0] d;
        do_write(3'd7, 32'hFFFF_FFFF);
        do_read(3'd7, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reserved_read: got %h want %h", d, 32'h0);
        else pass_cnt++;
        do_read(3'd0, d);
        total_cnt++;
        if (d !== 32'h155) $display("FAIL reserved_no_effect: got %h want %h", d, 32'h155);
        else pass_cnt++;
        do_write(3'd5, 32'h0000_1234);
        do_read(3'd5, d);
        total_cnt++;
        if (d !== 32'h34) $display("FAIL dim_width: got %h want %h", d, 32'h34);
        else pass_cnt++;
        do_write(3'd3, 32'hFFFF_FFFF);
        do_read(3'd3, d);
        total_cnt++;
        if (d !== 32'h3FF) $display("FAIL blink_en_width: got %h want %h", d, 32'h3FF);
        else pass_cnt++;
        do_write(3'd3, 32'h0);
        do_write(3'd5, 32'hFF);
    endtask

    task automatic test_blink;
        logic [9:0] exp_out;
        do_write(3'd3, 32'h001);
        do_write(3'd0, 32'h003);
        do_write(3'd4, 32'd3);
        // phase is 1 for 4 clocks after the divider write, then 0 for 4; out_port lags by one
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            exp_out = (((i - 1) / 4) % 2 == 0) ? 10'h003 : 10'h002;
            total_cnt++;
            if (out_port !== exp_out) $display("FAIL blink_cycle%0d: got %h want %h", i, out_port, exp_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_restart;
        logic [31:0] d;
        // mid-count with phase 0: after R+5 count=1, phase=0
        do_write(3'd4, 32'd3);
        tick(4);
        do_write(3'd4, 32'd3);
        total_cnt++;
        if (out_port !== 10'h002) $display("FAIL restart_before: got %h want %h", out_port, 10'h002);
        else pass_cnt++;
        do_read(3'd6, d);
        total_cnt++;
        if (d !== STATUS_P1) $display("FAIL restart_phase: got %h want %h", d, STATUS_P1);
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 10'h003) $display("FAIL restart_out: got %h want %h", out_port, 10'h003);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if (out_port !== 10'h003) $display("FAIL restart_hold: got %h want %h", out_port, 10'h003);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (out_port !== 10'h002) $display("FAIL restart_toggle: got %h want %h", out_port, 10'h002);
        else pass_cnt++;
        // divider write exactly on terminal count: count was 3 before the edge
        do_write(3'd4, 32'd3);
        tick(3);
        do_write(3'd4, 32'd3);
        do_read(3'd6, d);
        total_cnt++;
        if (d !== STATUS_P1) $display("FAIL restart_terminal: got %h want %h", d, STATUS_P1);
        else pass_cnt++;
    endtask

    task automatic test_blink_data0;
        int nonzero;
        do_write(3'd3, 32'h3FF);
        do_write(3'd0, 32'h000);
        do_write(3'd4, 32'd1);
        tick(1);
        nonzero = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (out_port !== 10'h000) nonzero++;
        end
        total_cnt++;
        if (nonzero !== 0) $display("FAIL blink_data0: got %0d nonzero cycles want 0", nonzero);
        else pass_cnt++;
    endtask

    task automatic test_pwm;
        int dims [4];
        int exp_hi [4];
        int hi;
        int lo;
        dims   = '{64, 0, 255, 1};
        exp_hi = '{64, 0, 256, 1};
        do_write(3'd3, 32'h000);
        do_write(3'd0, 32'h3FF);
        for (int k = 0; k < 4; k++) begin
            do_write(3'd5, 32'(dims[k]));
            hi = 0;
            lo = 0;
            for (int i = 0; i < 256; i++) begin
                tick(1);
                if (out_port === 10'h3FF) hi++;
                else if (out_port === 10'h000) lo++;
            end
            total_cnt++;
            if (hi !== exp_hi[k] || lo !== 256 - exp_hi[k])
                $display("FAIL pwm_dim%0d: got %0d high %0d low want %0d high %0d low",
                         dims[k], hi, lo, exp_hi[k], 256 - exp_hi[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        do_write(3'd5, 32'hFF);
        do_write(3'd3, 32'h001);
        do_write(3'd0, 32'h3FF);
        do_write(3'd4, 32'd3);
        tick(2);
        total_cnt++;
        if (out_port !== 10'h3FF) $display("FAIL areset_pre: got %h want %h", out_port, 10'h3FF);
        else pass_cnt++;
        do_read(3'd0, d);
        #3 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_port !== 10'h000) $display("FAIL areset_out_port: got %h want %h", out_port, 10'h000);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL areset_readdata: got %h want %h", readdata, 32'h0);
        else pass_cnt++;
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        do_read(3'd6, d);
        total_cnt++;
        if (d !== STATUS_P1) $display("FAIL areset_phase: got %h want %h", d, STATUS_P1);
        else pass_cnt++;
        do_read(3'd0, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL areset_data: got %h want %h", d, 32'h0);
        else pass_cnt++;
        do_read(3'd4, d);
        total_cnt++;
        if (d !== 32'd12_499_999) $display("FAIL areset_div: got %h want %h", d, 32'd12_499_999);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = 32'h0;
        #2;
        test_reset();
        test_set_clr();
        test_rw_same_cycle();
        test_width_reserved();
        test_blink();
        test_restart();
        test_blink_data0();
        test_pwm();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gpu_led_pio.md
# gpu_led_pio

Parametrised Avalon-MM output PIO for the GPU Qsys system that drives board LEDs or other status pins. It adds atomic per-bit set and clear, per-channel blink with a programmable prescaler, and a global PWM dimmer. The block sits on the Nios/host Avalon-MM fabric as a slave with one-cycle read latency, and its `out_port` pins go to the board.

## Interface
Parameters:
- `WIDTH`, default 10: number of output channels, legal range 1..32.
- `DIV_W`, default 24: width of the blink divider register, legal range 1..32.
- `BLINK_DIV_RST`, default 12_499_999: reset value of BLINK_DIV, giving a 0.25 s half-period at 50 MHz.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `read_n` in 1: read strobe, active-low.
- `write_n` in 1: write strobe, active-low.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `out_port` out WIDTH: registered channel outputs.

## Operation
A write occurs when `chipselect & ~write_n`. A read occurs when `chipselect & ~read_n`. Bits of `writedata` above a register's width are ignored. Unused `readdata` bits read 0.

Register map:
- 0 DATA (RW, WIDTH bits, reset 0): channel enables.
- 1 SET (WO): `DATA <= DATA | wd[WIDTH-1:0]`. Reads return 0.
- 2 CLR (WO): `DATA <= DATA & ~wd[WIDTH-1:0]`. Reads return 0.
- 3 BLINK_EN (RW, WIDTH bits, reset 0): per-channel blink mask.
- 4 BLINK_DIV (RW, DIV_W bits, reset `BLINK_DIV_RST`): blink half-period is BLINK_DIV+1 clocks. Any write also clears the blink counter and sets phase to 1.
- 5 DIM (RW, 8 bits, reset 0xFF): global duty.
- 6 STATUS (RO): bit0 = blink phase; bits[15:8] = WIDTH; bits[23:16] = DIV_W.
- 7 reserved: reads 0, writes are ignored.

Blink timer:
- `blink_cnt` (DIV_W bits) increments every clock.
- When `blink_cnt == BLINK_DIV`, `blink_cnt` goes to 0 and `phase` toggles.
- Reset state: `blink_cnt` = 0, `phase` = 1.
- BLINK_DIV = 0 makes `phase` toggle every clock.

PWM:
- `pwm_cnt` is 8 bits, free-running, and wraps 255 -> 0. It is reset to 0.
- `pwm_on = (DIM == 8'hFF) | (pwm_cnt < DIM)`.
- DIM = 0 forces all outputs low. DIM = 0xFF gives a constant on.

Output equation, registered:
- `out_port <= DATA & ~(BLINK_EN & {WIDTH{~phase}}) & {WIDTH{pwm_on}}`.

Boundary conditions:
- A read and a write in the same cycle: the write is performed, and `readdata` returns the pre-write value.
- Writes to SET/CLR with zero data leave DATA unchanged.
- A BLINK_DIV write in the same cycle as a terminal count: the write wins (count 0, phase 1).
- Blink-enabled channels with DATA=0 stay low in both phases.
- Reset mid-operation: all registers, counters and outputs return to their reset values immediately (asynchronous).

## Timing
- Reset values: `out_port` = 0, `readdata` = 0.
- Read latency is 1 clock. `readdata` is valid in the cycle after the read strobe. It holds its value when there is no read.
- Write to `out_port`: a register write at edge N is visible on `out_port` after edge N+1.
- Blink period is 2*(BLINK_DIV+1) clocks. Phase transitions appear on `out_port` one clock after `phase` changes.
- PWM period is 256 clocks. A DIM value of d gives d high cycles per period, for d < 255.
- No wait states. The slave accepts one access per cycle.

## Structure
- Package `gpu_led_pio_pkg` holds:
  - register word-address localparams: `REG_DATA` = 0, `REG_SET`, `REG_CLR`, `REG_BLINK_EN`, `REG_BLINK_DIV`, `REG_DIM`, `REG_STATUS`;
  - the `DIM_FULL` = 8'hFF constant.
- Sub-module `gpu_led_blink_timer` contains:
  - parameter `DIV_W`;
  - ports `clk`, `reset_n`, `div`, `restart`, `phase`.
- The top level contains the register file, the PWM counter, the output register and the read mux.

## Test plan
- Reset, then read all addresses. Required: `out_port` = 0, DATA = 0, BLINK_DIV = 12_499_999, DIM = 0xFF, STATUS = 0x00180A01.
- Write DATA = 0x3A5, then SET 0x00F, then CLR 0x300. Required: DATA reads 0x0AF; `out_port` = 0x0AF two clocks after the last write.
- BLINK_DIV = 3, BLINK_EN = 0x001, DATA = 0x003. Required: bit0 of `out_port` alternates with 4 clocks high and 4 clocks low; bit1 stays constant 1.
- DIM = 64 with DATA = 0x3FF. Required: each channel is high for exactly 64 of 256 clocks. DIM = 0 forces 0x000. DIM = 0xFF gives constant 0x3FF.
- Write BLINK_DIV mid-count while phase = 0. Required: the next cycle shows phase = 1 and the counter restarts from 0.
- Assert `reset_n` low mid-blink with DATA = 0x3FF. Required: `out_port` goes to 0 asynchronously; after release, the blink timer restarts with phase = 1.
